// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide unit.
// Provides the operation encoding seen on the op port, the control FSM
// state encoding, and the default operand width.
package muldiv_pkg;

    localparam int MD_WIDTH = 32;

    typedef enum logic [1:0] {
        OP_MULTU = 2'b00,
        OP_DIVU  = 2'b01,
        OP_MTHI  = 2'b10,
        OP_MTLO  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_e;

endpackage : muldiv_pkg

// File: rtl/muldiv_step.sv
// One combinational iteration of the shift-add multiplier / restoring divider.
//
// Ports:
//   acc_i   [2*WIDTH-1:0]  current accumulator
//                          multiply: {partial product, remaining multiplier}
//                          divide:   {partial remainder, dividend/quotient}
//   opnd_i  [WIDTH-1:0]    multiplicand (multiply) or divisor (divide)
//   div_i                  1 = divide step, 0 = multiply step
//   acc_o   [2*WIDTH-1:0]  accumulator after this iteration
module muldiv_step
    import muldiv_pkg::*;
#(
    parameter int WIDTH = MD_WIDTH
) (
    input  logic [2*WIDTH-1:0] acc_i,
    input  logic [WIDTH-1:0]   opnd_i,
    input  logic               div_i,
    output logic [2*WIDTH-1:0] acc_o
);

    logic [WIDTH:0]     sum;
    logic [WIDTH:0]     upper_sel;
    logic [2*WIDTH-1:0] mul_next;
    logic [WIDTH:0]     rem_sh;
    logic [WIDTH-1:0]   diff;
    logic               q_bit;
    logic [WIDTH-1:0]   rem_next;
    logic [2*WIDTH-1:0] div_next;

    always_comb begin
        // Multiply: conditional add into the upper half keeps its carry in a
        // 33rd bit, which the right shift then brings back into range.
        sum       = {1'b0, acc_i[2*WIDTH-1:WIDTH]} + {1'b0, opnd_i};
        upper_sel = acc_i[0] ? sum : {1'b0, acc_i[2*WIDTH-1:WIDTH]};
        mul_next  = {upper_sel, acc_i[WIDTH-1:1]};

        // Divide: shift the next dividend bit into the remainder, then keep the
        // difference only if the divisor fits. The remainder is always below
        // the divisor, so a WIDTH-bit difference never loses information.
        rem_sh   = acc_i[2*WIDTH-1:WIDTH-1];
        q_bit    = (rem_sh >= {1'b0, opnd_i});
        diff     = rem_sh[WIDTH-1:0] - opnd_i;
        rem_next = q_bit ? diff : rem_sh[WIDTH-1:0];
        div_next = {rem_next, acc_i[WIDTH-2:0], q_bit};

        acc_o = div_i ? div_next : mul_next;
    end

endmodule : muldiv_step

// File: rtl/muldiv_unit.sv
// Iterative unsigned multiply/divide unit with HI/LO result registers.
// MULTU/DIVU take 32 iterations (busy), then pulse done for one cycle while
// HI/LO hold the result; MTHI/MTLO write HI/LO in a single cycle.
//
// Ports:
//   clk       clock, rising edge
//   rst_n     asynchronous active-low reset
//   start     request, honoured only in IDLE/DONE and without flush
//   op        00 MULTU, 01 DIVU, 10 MTHI, 11 MTLO
//   flush     abort in-flight work; HI/LO/div_zero untouched
//   dataA     multiplicand / dividend / MTHI-MTLO source
//   dataB     multiplier / divisor
//   busy      iteration in progress
//   done      one-cycle pulse after MULTU/DIVU commit
//   div_zero  sticky: last completed DIVU had a zero divisor
//   hi, lo    HI/LO registers
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH = MD_WIDTH,
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic             flush,
    input  logic [WIDTH-1:0] dataA,
    input  logic [WIDTH-1:0] dataB,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    if ((1 << CNT_W) != WIDTH) begin : g_cnt_check
        $error("muldiv_unit: 2**CNT_W must equal WIDTH");
    end

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   opnd_q, opnd_d;
    logic               div_q, div_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               dz_q, dz_d;
    logic [2*WIDTH-1:0] acc_step;

    muldiv_step #(.WIDTH(WIDTH)) u_step (
        .acc_i  (acc_q),
        .opnd_i (opnd_q),
        .div_i  (div_q),
        .acc_o  (acc_step)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            opnd_q  <= '0;
            div_q   <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            opnd_q  <= opnd_d;
            div_q   <= div_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            dz_q    <= dz_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        opnd_d  = opnd_q;
        div_d   = div_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        dz_d    = dz_q;

        if (flush) begin
            // Flush beats everything, including a same-cycle start.
            state_d = ST_IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                ST_RUN: begin
                    acc_d = acc_step;
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CNT_LAST) begin
                        hi_d    = acc_step[2*WIDTH-1:WIDTH];
                        lo_d    = acc_step[WIDTH-1:0];
                        state_d = ST_DONE;
                        cnt_d   = '0;
                        if (div_q) begin
                            dz_d = (opnd_q == '0);
                        end
                    end
                end
                default: begin
                    // IDLE and DONE both accept a new request, so operations
                    // can follow each other without a bubble.
                    state_d = ST_IDLE;
                    if (start) begin
                        case (op)
                            OP_MULTU: begin
                                opnd_d  = dataA;
                                acc_d   = {{WIDTH{1'b0}}, dataB};
                                div_d   = 1'b0;
                                cnt_d   = '0;
                                state_d = ST_RUN;
                            end
                            OP_DIVU: begin
                                opnd_d  = dataB;
                                acc_d   = {{WIDTH{1'b0}}, dataA};
                                div_d   = 1'b1;
                                cnt_d   = '0;
                                state_d = ST_RUN;
                            end
                            OP_MTHI: hi_d = dataA;
                            default: lo_d = dataA;
                        endcase
                    end
                end
            endcase
        end
    end

    assign busy     = (state_q == ST_RUN);
    assign done     = (state_q == ST_DONE);
    assign div_zero = dz_q;
    assign hi       = hi_q;
    assign lo       = lo_q;

endmodule : muldiv_unit

// File: tb/tb_muldiv_unit.sv
module tb_muldiv_unit;
    import muldiv_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        flush = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [31:0] dataA = '0;
    logic [31:0] dataB = '0;
    logic        busy, done, div_zero;
    logic [31:0] hi, lo;

    int checks = 0;
    int errors = 0;

    muldiv_unit #(.WIDTH(32), .CNT_W(5)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .op       (op),
        .flush    (flush),
        .dataA    (dataA),
        .dataB    (dataB),
        .busy     (busy),
        .done     (done),
        .div_zero (div_zero),
        .hi       (hi),
        .lo       (lo)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog act=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [1:0]  o;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] ehi;
        logic [31:0] elo;
        logic        edz;
    } vec_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%0h exp=%0h", name, act, exp);
        end
    endtask

    // Reference model: results from plain arithmetic on the operation's meaning.
    task automatic model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                         inout logic [31:0] h, inout logic [31:0] l, inout logic dz);
        logic [63:0] p;
        case (o)
            2'b00: begin
                p = 64'(a) * 64'(b);
                h = p[63:32];
                l = p[31:0];
            end
            2'b01: begin
                if (b == 0) begin
                    l = 32'hFFFFFFFF;
                    h = a;
                end else begin
                    l = a / b;
                    h = a % b;
                end
                dz = (b == 0);
            end
            2'b10: h = a;
            default: l = a;
        endcase
    endtask

    // Issue one request and check its timing and result. inject_at >= 0 drives
    // a stray MTLO start at that busy cycle, which must be ignored.
    task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                          input int inject_at, input logic [31:0] ehi, input logic [31:0] elo,
                          input logic edz, input string tag);
        int n;
        @(negedge clk);
        op = o; dataA = a; dataB = b; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        dataA = $urandom;
        dataB = $urandom;
        if (o[1]) begin
            chk({tag, "_busy"}, 64'(busy), 64'd0);
            chk({tag, "_done"}, 64'(done), 64'd0);
        end else begin
            n = 0;
            while (busy && n < 40) begin
                if (n == inject_at) begin
                    start = 1'b1; op = OP_MTLO; dataA = 32'd9;
                end
                @(negedge clk);
                start = 1'b0;
                n++;
            end
            chk({tag, "_busy_cycles"}, 64'(n), 64'd32);
            chk({tag, "_done"}, 64'(done), 64'd1);
        end
        chk({tag, "_hi"}, 64'(hi), 64'(ehi));
        chk({tag, "_lo"}, 64'(lo), 64'(elo));
        chk({tag, "_dz"}, 64'(div_zero), 64'(edz));
    endtask

    initial begin
        vec_t        vecs [9];
        logic [31:0] mh, ml, ra, rb;
        logic        mdz, seen;
        logic [1:0]  ro;
        int          n;

        vecs[0] = '{2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0};
        vecs[1] = '{2'b01, 32'd100,      32'd7,        32'd2,        32'd14,       1'b0};
        vecs[2] = '{2'b01, 32'd5,        32'd0,        32'd5,        32'hFFFFFFFF, 1'b1};
        vecs[3] = '{2'b10, 32'hDEADBEEF, 32'd0,        32'hDEADBEEF, 32'hFFFFFFFF, 1'b1};
        vecs[4] = '{2'b00, 32'd3,        32'd4,        32'd0,        32'd12,       1'b1};
        vecs[5] = '{2'b00, 32'h00010000, 32'h00010000, 32'd1,        32'd0,        1'b1};
        vecs[6] = '{2'b01, 32'hFFFFFFFF, 32'd1,        32'd0,        32'hFFFFFFFF, 1'b0};
        vecs[7] = '{2'b01, 32'd7,        32'd100,      32'd7,        32'd0,        1'b0};
        vecs[8] = '{2'b11, 32'h12345678, 32'd0,        32'd7,        32'h12345678, 1'b0};

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_dz", 64'(div_zero), 64'd0);
        chk("rst_hi", 64'(hi), 64'd0);
        chk("rst_lo", 64'(lo), 64'd0);
        rst_n = 1'b1;

        // Reset in the middle of a MULTU clears everything immediately
        run_op(OP_MTHI, 32'h55, 32'd0, -1, 32'h55, 32'd0, 1'b0, "pre_rst");
        @(negedge clk);
        op = OP_MULTU; dataA = 32'd7; dataB = 32'd6; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (8) @(negedge clk);
        chk("midrst_busy_before", 64'(busy), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("midrst_busy", 64'(busy), 64'd0);
        chk("midrst_done", 64'(done), 64'd0);
        chk("midrst_hi", 64'(hi), 64'd0);
        chk("midrst_lo", 64'(lo), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (done || busy) seen = 1'b1;
        end
        chk("midrst_no_activity", 64'(seen), 64'd0);

        // Table-driven vectors
        for (int i = 0; i < 9; i++) begin
            run_op(vecs[i].o, vecs[i].a, vecs[i].b, -1, vecs[i].ehi, vecs[i].elo,
                   vecs[i].edz, $sformatf("vec%0d", i));
        end

        // MTHI then MTLO on consecutive cycles
        @(negedge clk);
        op = OP_MTHI; dataA = 32'hDEADBEEF; start = 1'b1;
        @(negedge clk);
        chk("mthi_hi", 64'(hi), 64'hDEADBEEF);
        chk("mthi_busy", 64'(busy | done), 64'd0);
        op = OP_MTLO; dataA = 32'h12345678;
        @(negedge clk);
        start = 1'b0;
        chk("mtlo_lo", 64'(lo), 64'h12345678);
        chk("mtlo_hi", 64'(hi), 64'hDEADBEEF);
        chk("mtlo_busy", 64'(busy | done), 64'd0);

        // Start while busy is ignored
        run_op(OP_MULTU, 32'd3, 32'd4, 5, 32'd0, 32'd12, 1'b0, "ign");

        // Back-to-back: a start in the DONE cycle is taken without a bubble
        op = OP_MTLO; dataA = 32'd5; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("b2b_lo", 64'(lo), 64'd5);
        chk("b2b_done", 64'(done), 64'd0);

        // Flush mid-DIVU keeps prior HI/LO and produces no done
        run_op(OP_MTHI, 32'd1, 32'd0, -1, 32'd1, 32'd5, 1'b0, "fl_hi");
        run_op(OP_MTLO, 32'd2, 32'd0, -1, 32'd1, 32'd2, 1'b0, "fl_lo");
        @(negedge clk);
        op = OP_DIVU; dataA = 32'd50; dataB = 32'd5; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (19) @(negedge clk);
        chk("flush_busy_before", 64'(busy), 64'd1);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("flush_busy", 64'(busy), 64'd0);
        seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (done || busy) seen = 1'b1;
        end
        chk("flush_no_done", 64'(seen), 64'd0);
        chk("flush_hi", 64'(hi), 64'd1);
        chk("flush_lo", 64'(lo), 64'd2);

        // Start together with flush: nothing starts or is written
        op = OP_MTHI; dataA = 32'hAAAA5555; start = 1'b1; flush = 1'b1;
        @(negedge clk);
        chk("sf_mthi_hi", 64'(hi), 64'd1);
        op = OP_MULTU; dataA = 32'd9; dataB = 32'd9;
        @(negedge clk);
        start = 1'b0; flush = 1'b0;
        chk("sf_mult_busy", 64'(busy), 64'd0);

        // Randomized operations against the reference model
        mh = hi; ml = lo; mdz = div_zero;
        for (int i = 0; i < 30; i++) begin
            ro = 2'($urandom_range(0, 3));
            ra = $urandom;
            n  = int'($urandom_range(0, 3));
            rb = (n == 0) ? 32'd0 : (n == 1) ? 32'($urandom_range(1, 255)) : $urandom;
            model(ro, ra, rb, mh, ml, mdz);
            run_op(ro, ra, rb, -1, mh, ml, mdz, $sformatf("rnd%0d", i));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_muldiv_unit
